// File: rtl/fractal_sync_tx.sv
// fractal_sync_tx: initiator end of the fractal-sync barrier protocol.
// Takes one barrier request (level, id) from the core, issues a single check
// transfer to the synchronization node, waits for the matching wake and then
// answers the core with a completion or error response.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a new barrier request
//   ISSUE | check transfer presented to the node, waiting for net_ready_i
//   WAIT  | check accepted, waiting for matching wake (timeout running)
//   RESP  | response presented to the core, waiting for rsp_ready_i
module fractal_sync_tx #(
  parameter int unsigned  LVL_WIDTH      = 4,
  parameter int unsigned  ID_WIDTH       = 4,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  parameter int unsigned  CNT_WIDTH      = 8,
  localparam int unsigned SIG_WIDTH      = LVL_WIDTH + ID_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LVL_WIDTH-1:0] req_level_i,
  input  logic [ID_WIDTH-1:0]  req_id_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_error_o,
  output logic [SIG_WIDTH-1:0] rsp_sig_o,
  output logic                 check_o,
  output logic [SIG_WIDTH-1:0] sig_o,
  output logic                 sig_valid_o,
  input  logic                 net_ready_i,
  input  logic                 wake_valid_i,
  input  logic [SIG_WIDTH-1:0] wake_sig_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] stray_cnt_o
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned    TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q;
  logic                 req_ready_q;
  logic                 check_q;
  logic                 sig_valid_q;
  logic                 rsp_valid_q;
  logic                 error_q;
  logic [SIG_WIDTH-1:0] sig_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [CNT_WIDTH-1:0] stray_q;

  logic req_fire;
  logic wake_match;
  logic transfer;
  logic wake_completes;

  assign req_fire   = req_valid_i & req_ready_q;
  assign wake_match = wake_valid_i & (wake_sig_i == sig_q);
  assign transfer   = (state_q == ISSUE) & net_ready_i;

  // A wake only completes a barrier when it matches in the transfer cycle or in WAIT.
  assign wake_completes = wake_match & (transfer | (state_q == WAIT));

  // Barrier sequencing; all core/node handshake outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      check_q     <= 1'b0;
      sig_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      error_q     <= 1'b0;
      sig_q       <= '0;
      to_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            sig_q       <= {req_level_i, req_id_i};
            req_ready_q <= 1'b0;
            if (req_level_i == '0) begin
              // Level 0 is not a valid barrier: answer with an error, never touch the node.
              error_q     <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              error_q     <= 1'b0;
              check_q     <= 1'b1;
              sig_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (net_ready_i) begin
            check_q  <= 1'b0;
            to_cnt_q <= '0;
            if (wake_match) begin
              sig_valid_q <= 1'b0;
              rsp_valid_q <= 1'b1;
              error_q     <= 1'b0;
              state_q     <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wake_match) begin
            // A match in the expiry cycle still counts as a clean completion.
            sig_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            error_q     <= 1'b0;
            state_q     <= RESP;
          end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
            sig_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          check_q     <= 1'b0;
          sig_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of wakes that did not complete a barrier, at most +1 per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stray_q <= '0;
    end else if (wake_valid_i && !wake_completes && (stray_q != '1)) begin
      stray_q <= stray_q + 1'b1;
    end
  end

  assign req_ready_o = req_ready_q;
  assign check_o     = check_q;
  assign sig_valid_o = sig_valid_q;
  assign sig_o       = sig_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = error_q;
  assign rsp_sig_o   = sig_q;
  assign busy_o      = (state_q != IDLE);
  assign stray_cnt_o = stray_q;

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Testbench for fractal_sync_tx: directed vector table, hand-written reset and
// saturation sequences, and randomized barriers checked against a
// transaction-level timing model.
module tb_fractal_sync_tx;

  localparam int TO = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_level_i;
  logic [3:0] req_id_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic       rsp_error_o;
  logic [7:0] rsp_sig_o;
  logic       check_o;
  logic [7:0] sig_o;
  logic       sig_valid_o;
  logic       net_ready_i;
  logic       wake_valid_i;
  logic [7:0] wake_sig_i;
  logic       busy_o;
  logic [7:0] stray_cnt_o;

  int tests = 0;
  int fails = 0;
  int stray_m = 0;

  fractal_sync_tx #(
    .LVL_WIDTH(4), .ID_WIDTH(4), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_level_i(req_level_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_error_o(rsp_error_o), .rsp_sig_o(rsp_sig_o),
    .check_o(check_o), .sig_o(sig_o), .sig_valid_o(sig_valid_o),
    .net_ready_i(net_ready_i),
    .wake_valid_i(wake_valid_i), .wake_sig_i(wake_sig_i),
    .busy_o(busy_o), .stray_cnt_o(stray_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] id;
    int         d;      // cycles net_ready_i held low in ISSUE
    int         k;      // cycles from transfer to matching wake (0 = same cycle)
    int         r;      // cycles rsp_ready_i held low after rsp_valid_o
    int         noise;  // 0 none, 1 wake 0x11 every cycle, 2 random mismatching wakes
    logic       exp_err;
    int         exp_lat;
    int         exp_late;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid_i  = 1'b0;
    req_level_i  = '0;
    req_id_i     = '0;
    rsp_ready_i  = 1'b0;
    net_ready_i  = 1'b0;
    wake_valid_i = 1'b0;
    wake_sig_i   = '0;
  endtask

  // Expected outcome from the barrier rules: transfer lands d cycles after ISSUE
  // starts, the wake k cycles later must fall inside the TO-cycle WAIT window.
  function automatic void model(input logic [3:0] lvl, input int d, input int k, input int r,
                                output logic err, output int lat, output int late);
    if (lvl == 4'd0) begin
      err = 1'b1; lat = 1; late = 0;
    end else if (k <= TO) begin
      err = 1'b0; lat = d + k + 2; late = 0;
    end else begin
      err  = 1'b1;
      lat  = d + TO + 2;
      late = ((1 + d + k) <= (lat + r)) ? 1 : 0;
    end
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] sig;
    int         first, chk, sv, ncnt, exp_chk, exp_sv;
    logic       err_seen;
    logic [7:0] rsig_seen;
    bit         hs, done;
    sig = {v.lvl, v.id};
    first = -1; chk = 0; sv = 0; ncnt = 0;
    err_seen = 1'bx; rsig_seen = 'x;
    hs = 1'b0; done = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk_i);
      if (hs) begin
        check({tag, ".busy_after"}, busy_o, 1'b0);
        check({tag, ".ready_after"}, req_ready_o, 1'b1);
        drive_idle();
        done = 1'b1;
        break;
      end
      if (j == 0) begin
        check({tag, ".req_ready"}, req_ready_o, 1'b1);
      end else begin
        if (check_o && sig_o == sig) chk++;
        if (sig_valid_o) sv++;
        if (rsp_valid_o && first < 0) begin
          first     = j;
          err_seen  = rsp_error_o;
          rsig_seen = rsp_sig_o;
        end
      end
      req_valid_i  = (j == 0);
      req_level_i  = v.lvl;
      req_id_i     = v.id;
      net_ready_i  = (j >= 1 + v.d);
      wake_valid_i = 1'b0;
      wake_sig_i   = '0;
      if (v.lvl != 4'd0 && j == 1 + v.d + v.k) begin
        wake_valid_i = 1'b1;
        wake_sig_i   = sig;
      end else if (v.noise == 1 || (v.noise == 2 && $urandom_range(3) == 0)) begin
        wake_valid_i = 1'b1;
        wake_sig_i   = (v.noise == 1) ? 8'h11 : (sig ^ 8'($urandom_range(255, 1)));
        ncnt++;
      end
      rsp_ready_i = (first >= 0) && (j >= first + v.r);
      if (rsp_ready_i && rsp_valid_o) hs = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s.handshake: got none expected rsp handshake within 200 cycles", tag);
      drive_idle();
    end
    exp_chk = (v.lvl != 4'd0) ? v.d + 1 : 0;
    exp_sv  = (v.lvl != 4'd0) ? v.exp_lat - 1 : 0;
    check({tag, ".latency"}, first, v.exp_lat);
    check({tag, ".rsp_error"}, err_seen, v.exp_err);
    check({tag, ".rsp_sig"}, rsig_seen, sig);
    check({tag, ".check_cycles"}, chk, exp_chk);
    check({tag, ".sig_valid_cycles"}, sv, exp_sv);
    stray_m = stray_m + ncnt + v.exp_late;
    if (stray_m > 255) stray_m = 255;
    check({tag, ".stray"}, stray_cnt_o, stray_m);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t rv;
    //          lvl   id    d  k   r  noise err   lat late
    vecs[0] = '{4'd2, 4'd5, 0, 3,  0, 0,    1'b0, 5,  0};  // basic barrier
    vecs[1] = '{4'd2, 4'd5, 5, 3,  1, 0,    1'b0, 10, 0};  // node backpressure
    vecs[2] = '{4'd2, 4'd5, 0, 0,  0, 0,    1'b0, 2,  0};  // wake in transfer cycle
    vecs[3] = '{4'd0, 4'd3, 0, 0,  2, 0,    1'b1, 1,  0};  // illegal level
    vecs[4] = '{4'd2, 4'd2, 0, 31, 0, 1,    1'b1, 10, 0};  // timeout with 0x11 strays
    vecs[5] = '{4'd1, 4'd7, 2, 8,  0, 0,    1'b0, 12, 0};  // match in expiry cycle
    vecs[6] = '{4'd3, 4'd1, 1, 9,  0, 0,    1'b1, 11, 1};  // match one cycle too late
    vecs[7] = '{4'd4, 4'd9, 0, 2,  0, 1,    1'b0, 4,  0};  // strays around a clean barrier
    vecs[8] = '{4'd2, 4'd5, 5, 8,  0, 0,    1'b0, 15, 0};  // no timeout counting in ISSUE

    drive_idle();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset.req_ready", req_ready_o, 1'b1);
    check("reset.rsp_valid", rsp_valid_o, 1'b0);
    check("reset.rsp_error", rsp_error_o, 1'b0);
    check("reset.check", check_o, 1'b0);
    check("reset.sig_valid", sig_valid_o, 1'b0);
    check("reset.sig", sig_o, 8'h00);
    check("reset.rsp_sig", rsp_sig_o, 8'h00);
    check("reset.busy", busy_o, 1'b0);
    check("reset.stray", stray_cnt_o, 8'h00);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for a wake, with some stray wakes already counted.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_level_i = 4'd2; req_id_i = 4'd5; net_ready_i = 1'b1;
    wake_valid_i = 1'b1; wake_sig_i = 8'h11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("midwait.busy_before", busy_o, 1'b1);
    check("midwait.stray_before", stray_cnt_o, stray_m + 3 > 255 ? 255 : stray_m + 3);
    drive_idle();
    rst_ni = 1'b0;
    #1;
    check("midwait.busy", busy_o, 1'b0);
    check("midwait.req_ready", req_ready_o, 1'b1);
    check("midwait.stray", stray_cnt_o, 8'h00);
    check("midwait.check", check_o, 1'b0);
    check("midwait.rsp_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    stray_m = 0;
    run_txn(vecs[0], "after_reset");

    for (int n = 0; n < 150; n++) begin
      rv.lvl = ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom_range(15));
      rv.id  = 4'($urandom_range(15));
      rv.d   = $urandom_range(4);
      rv.k   = ($urandom_range(5) == 0) ? 31 : $urandom_range(12);
      rv.r   = $urandom_range(3);
      rv.noise = 2;
      model(rv.lvl, rv.d, rv.k, rv.r, rv.exp_err, rv.exp_lat, rv.exp_late);
      run_txn(rv, $sformatf("rand%0d", n));
    end

    // Stray counter counts idle wakes one per cycle and saturates.
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    wake_valid_i = 1'b1;
    wake_sig_i   = 8'h11;
    repeat (200) @(negedge clk_i);
    check("sat.count200", stray_cnt_o, 8'd200);
    repeat (100) @(negedge clk_i);
    drive_idle();
    @(negedge clk_i);
    check("sat.count300", stray_cnt_o, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fractal_sync_tx.md
Name: fractal_sync_tx

Overview:
- Initiator end of the fractal-sync barrier protocol, one instance per tile port.
- Accepts barrier requests (level, id) from the core and encodes them into a signature.
- Issues one check transfer towards the synchronization node CAM, then waits for the matching wake notification.
- Returns a completion or error response to the core; one barrier outstanding at a time.

Parameters:
- LVL_WIDTH, 4, width of barrier level field
- ID_WIDTH, 4, width of barrier id field
- SIG_WIDTH, LVL_WIDTH+ID_WIDTH, signature width (localparam, not overridable)
- TIMEOUT_CYCLES, 1024, wait-state timeout; 0 disables timeout
- CNT_WIDTH, 8, width of stray-wake counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  core barrier request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_level_i  in  LVL_WIDTH  barrier level
- req_id_i  in  ID_WIDTH  barrier id
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  core accepts response
- rsp_error_o  out  1  1 = illegal level or timeout
- rsp_sig_o  out  SIG_WIDTH  signature of completed barrier
- check_o  out  1  check request to node
- sig_o  out  SIG_WIDTH  signature to node
- sig_valid_o  out  1  signature valid to node
- net_ready_i  in  1  node accepts check (transfer = check_o & net_ready_i)
- wake_valid_i  in  1  wake notification from node
- wake_sig_i  in  SIG_WIDTH  signature of wake
- busy_o  out  1  barrier in flight (state != IDLE)
- stray_cnt_o  out  CNT_WIDTH  saturating count of ignored wakes

Behaviour:
- Reset values:
  - state IDLE
  - req_ready_o=1, all other 1-bit outputs 0
  - sig_o, rsp_sig_o, timeout counter, stray_cnt_o all 0
- Signature encoding: sig = {level, id}, level in the MSBs. Registered at request acceptance.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On valid&ready with level==0: latch sig, rsp_error_o=1, go to RESP. Nothing is issued to the node.
  - On valid&ready with level!=0: latch sig, go to ISSUE.
- ISSUE:
  - check_o=1 and sig_valid_o=1; sig_o=latched sig, held stable until transfer.
  - On transfer with a matching wake in the same cycle: go to RESP with error=0.
  - On transfer without a matching wake: go to WAIT and clear the timeout counter.
  - Without transfer: stay in ISSUE. The timeout counter does not run in ISSUE.
- WAIT:
  - check_o=0, sig_valid_o=1, sig_o held.
  - Matching wake (wake_valid_i & wake_sig_i==sig): go to RESP, error=0.
  - Otherwise the counter increments each cycle. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without a match: go to RESP, error=1.
  - A match in the expiry cycle wins: error=0.
- RESP:
  - rsp_valid_o=1, rsp_sig_o=latched sig, rsp_error_o held stable, sig_valid_o=0.
  - On rsp_ready_i: go to IDLE.
  - req_ready_o=0 during RESP; a new request is accepted at the earliest in the cycle after the handshake.
- Stray wakes:
  - Any wake_valid_i that does not complete a barrier increments stray_cnt_o, saturating at all-ones.
  - This covers wakes in IDLE or RESP, mismatching signatures, and wakes in ISSUE without transfer.
  - At most +1 per cycle.
- Latency: minimum request-to-response is 2 cycles (accept in IDLE, issue+wake in ISSUE, rsp_valid in the following cycle).
- Reset mid-operation: immediate return to IDLE, outstanding barrier dropped, stray counter cleared.
- Outputs check_o, sig_valid_o, req_ready_o, rsp_valid_o decode from registered state only. There is no combinational path from net_ready_i or wake_* to outputs.

Test Plan:
- Basic barrier: level=2, id=5, net_ready_i=1; wake sig=0x25 three cycles after transfer. Expect one check_o pulse with sig_o=0x25, then rsp_valid_o=1, rsp_error_o=0, rsp_sig_o=0x25, busy_o low after rsp handshake.
- Backpressure: net_ready_i=0 for 5 cycles then 1. Expect check_o/sig_o=0x25 held stable 6 cycles, exactly one transfer, no timeout counting during ISSUE.
- Same-cycle wake: wake sig=0x25 in the transfer cycle. Expect rsp_valid_o the next cycle, WAIT never entered, stray_cnt_o=0.
- Illegal level: level=0, id=3. Expect no check_o, rsp_valid_o with rsp_error_o=1, rsp_sig_o=0x03.
- Timeout and stray: TIMEOUT_CYCLES=8, wakes sig=0x11 during WAIT and none matching. Expect rsp_error_o=1 after 8 WAIT cycles, stray_cnt_o equal to the number of 0x11 wakes; 300 wakes saturate at 255.
- Reset mid-WAIT: assert rst_ni=0 while in WAIT. Expect busy_o=0, req_ready_o=1, stray_cnt_o=0, and a subsequent request completing normally.
